btn_debounce: RTL and testbench

//  Input-side conditioner for the board buttons that feed the LED controller.

---
 rtl/btn_debounce.sv | 180 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: per-button 2-FF synchroniser plus a debounce FSM.
// Each channel produces a clean level, a one-cycle press pulse and a
// one-cycle release pulse. Define BTN_AUTOREPEAT_EN to add hold-to-repeat
// press pulses while a button stays down.

module btn_debounce_ch #(
  parameter int NB_COUNTER      = 32,
`ifdef BTN_AUTOREPEAT_EN
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000,
`endif
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse,
  output logic o_release
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

  localparam logic [NB_COUNTER-1:0] DEB_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [NB_COUNTER-1:0] HOLD_LAST = NB_COUNTER'(HOLD_CYCLES - 1);
  localparam logic [NB_COUNTER-1:0] REP_LAST  = NB_COUNTER'(REPEAT_CYCLES - 1);
  logic [NB_COUNTER-1:0] hold_q, hold_d;
  logic                  rep_q, rep_d;   // first repeat already issued
`endif

  state_e                state_q, state_d;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic                  s1_q, s2_q;
  logic                  level_q, level_d;
  logic                  pulse_q, pulse_d;
  logic                  release_q, release_d;

  // Next-state: qualify level changes on the synchronised input only
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    hold_d    = hold_q;
    rep_d     = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          hold_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        // hold counter restarts after every repeat; first gap is HOLD, then REPEAT
        else if (hold_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
          pulse_d = 1'b1;
          hold_d  = '0;
          rep_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // State, synchroniser and registered outputs
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      hold_q    <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      s1_q      <= i_btn;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_q    <= hold_d;
      rep_q     <= rep_d;
`endif
    end
  end

  assign o_level   = level_q;
  assign o_pulse   = pulse_q;
  assign o_release = release_q;

endmodule

module btn_debounce #(
  parameter int NB_SW           = 4,
  parameter int NB_COUNTER      = 32,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_btn,
  output logic [NB_SW-1:0] o_level,
  output logic [NB_SW-1:0] o_pulse,
  output logic [NB_SW-1:0] o_release
);

  localparam int MAX_CYC_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC   = (MAX_CYC_A > REPEAT_CYCLES) ? MAX_CYC_A : REPEAT_CYCLES;

  // Counters saturate at their compare value, so they only need to hold the largest one
  if ($clog2(MAX_CYC + 1) > NB_COUNTER) begin : g_bad_width
    $error("btn_debounce: NB_COUNTER too narrow for configured cycle counts");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar n = 0; n < NB_SW; n++) begin : g_ch
    btn_debounce_ch #(
      .NB_COUNTER      (NB_COUNTER),
`ifdef BTN_AUTOREPEAT_EN
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
`endif
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_btn     (i_btn[n]),
      .o_level   (o_level[n]),
      .o_pulse   (o_pulse[n]),
      .o_release (o_release[n])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE=4, HOLD=20, REPEAT=8, NB_SW=4.
// Cycle k below means "sampled 1 time unit after edge k", where edge 0 is the
// first edge that sees the new i_btn value.

module tb_btn_debounce;

  logic       clock;
  logic       i_reset;
  logic [3:0] i_btn;
  logic [3:0] o_level;
  logic [3:0] o_pulse;
  logic [3:0] o_release;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .NB_SW           (4),
    .NB_COUNTER      (32),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_btn     (i_btn),
    .o_level   (o_level),
    .o_pulse   (o_pulse),
    .o_release (o_release)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_b;

    // 1. reset holds everything low even with buttons pressed
    i_reset = 1'b0;
    i_btn   = 4'hF;
    step(); step(); step();
    chk("rst_level",   o_level,   4'h0);
    chk("rst_pulse",   o_pulse,   4'h0);
    chk("rst_release", o_release, 4'h0);
    i_btn   = 4'h0;
    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_level", o_level,   4'h0);
      chk("post_rst_pulse", o_pulse,   4'h0);
    end

    // 2. clean press on ch0: pulse exactly at edge 6, level from edge 6
    i_btn = 4'b0001;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk("ch0_pulse", {3'b0, o_pulse[0]}, {3'b0, k == 6});
      chk("ch0_level", {3'b0, o_level[0]}, {3'b0, k >= 6});
    end
    // clean release on ch0 is symmetric
    i_btn = 4'b0000;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk("ch0_release", {3'b0, o_release[0]}, {3'b0, k == 6});
      chk("ch0_rel_lvl", {3'b0, o_level[0]},   {3'b0, k < 6});
      chk("ch0_rel_pls", {3'b0, o_pulse[0]},   1'b0);
    end

    // 3. 3-cycle glitch on ch1 is rejected
    for (int k = 0; k < 14; k++) begin
      i_btn = (k < 3) ? 4'b0010 : 4'b0000;
      step();
      chk("ch1_glitch_pulse", {3'b0, o_pulse[1]}, 4'h0);
      chk("ch1_glitch_level", {3'b0, o_level[1]}, 4'h0);
    end

    // 4. ch2 pressed, then released with a 2-cycle high bounce
    i_btn = 4'b0100;
    for (int k = 0; k < 8; k++) step();
    chk("ch2_pressed", o_level, 4'b0100);
    for (int k = 0; k <= 11; k++) begin
      i_btn = (k == 1 || k == 2) ? 4'b0100 : 4'b0000;
      step();
      // bounce seen at edges 3..4 restarts qualification, release lands at edge 9
      chk("ch2_release", {3'b0, o_release[2]}, {3'b0, k == 9});
      chk("ch2_level",   {3'b0, o_level[2]},   {3'b0, k < 9});
      chk("ch2_no_pulse", {3'b0, o_pulse[2]},  4'h0);
    end

    // 5a. simultaneous presses on ch1 and ch3
    i_btn = 4'b1010;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk("simul_pulse", o_pulse, (k == 6) ? 4'b1010 : 4'b0000);
      chk("simul_level", o_level, (k >= 6) ? 4'b1010 : 4'b0000);
    end
    i_btn = 4'b0000;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk("simul_release", o_release, (k == 6) ? 4'b1010 : 4'b0000);
    end

    // 5b. reset mid-qualification discards progress and drops a held level
    i_btn = 4'b1000;
    for (int k = 0; k < 8; k++) step();
    chk("pre_rst_level", o_level, 4'b1000);
    i_btn = 4'b1001;
    for (int k = 0; k < 4; k++) step();   // ch0 now in PRESS_WAIT
    chk("pre_rst_pulse", o_pulse, 4'h0);
    i_reset = 1'b0;
    #1;
    chk("async_rst_level",   o_level,   4'h0);
    chk("async_rst_pulse",   o_pulse,   4'h0);
    chk("async_rst_release", o_release, 4'h0);
    i_btn = 4'b0000;
    step(); step();
    i_reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("after_rst_pulse",   o_pulse,   4'h0);
      chk("after_rst_level",   o_level,   4'h0);
      chk("after_rst_release", o_release, 4'h0);
    end

    // 6. ch3 held: press pulse at edge 6, repeats +20/+28/+36/+44 when enabled
    i_btn = 4'b1000;
    for (int k = 0; k <= 56; k++) begin
      step();
`ifdef BTN_AUTOREPEAT_EN
      exp_b = (k == 6) || (k == 26) || (k == 34) || (k == 42) || (k == 50);
`else
      exp_b = (k == 6);
`endif
      chk("ch3_hold_pulse", o_pulse, {exp_b, 3'b000});
      chk("ch3_hold_rel",   o_release, 4'h0);
    end
    i_btn = 4'b0000;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk("ch3_final_release", o_release, (k == 6) ? 4'b1000 : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
